// File: rtl/ifft_out_serializer_pkg.sv
// ---------------------------------------------------------------------------
// ifft_ser_pkg
// Shared types for the IFFT output serializer.
//   DW      : width of each real/imaginary sample (signed Q4.12)
//   SC_MAX  : bank depth in complex samples (one full 12-point IFFT result)
//   IDX_W   : width of the sample index / symbol length fields
//   cplx_t  : one complex sample {re, im}
//   nsc_e   : symbol size code as presented with the IFFT done strobe
//   nsc_len : number of samples emitted for a given size code
// ---------------------------------------------------------------------------
package ifft_ser_pkg;

    localparam int DW     = 16;
    localparam int SC_MAX = 12;
    localparam int IDX_W  = 4;

    typedef struct packed {
        logic signed [DW-1:0] re;
        logic signed [DW-1:0] im;
    } cplx_t;

    typedef enum logic [1:0] {
        NSC3    = 2'd0,
        NSC6    = 2'd1,
        NSC12   = 2'd2,
        NSC_RSV = 2'd3
    } nsc_e;

    // The reserved code is handled as a full 12-point symbol.
    function automatic logic [IDX_W-1:0] nsc_len(input nsc_e n);
        logic [IDX_W-1:0] len;
        case (n)
            NSC3:    len = 4'd3;
            NSC6:    len = 4'd6;
            default: len = 4'd12;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/ifft_out_serializer_bank.sv
// ---------------------------------------------------------------------------
// ifft_ser_bank
// One 12-entry complex sample bank plus the symbol length latched with it.
// Ports:
//   clk      : clock, rising edge
//   srst     : synchronous active-high reset, clears samples and length
//   cap_en   : capture strobe; all 12 samples and the length are written
//   cap_nsc  : symbol size code captured alongside the samples
//   cap_data : the 12 complex samples to capture
//   rd_idx   : sample index to present on rd_data
//   rd_data  : stored sample at rd_idx (zero for an out-of-range index)
//   len      : stored symbol length (3, 6 or 12; 0 after reset)
// ---------------------------------------------------------------------------
module ifft_ser_bank
    import ifft_ser_pkg::*;
(
    input  logic             clk,
    input  logic             srst,
    input  logic             cap_en,
    input  nsc_e             cap_nsc,
    input  cplx_t            cap_data [0:SC_MAX-1],
    input  logic [IDX_W-1:0] rd_idx,
    output cplx_t            rd_data,
    output logic [IDX_W-1:0] len
);

    cplx_t            mem_reg [0:SC_MAX-1];
    logic [IDX_W-1:0] len_reg;

    // Per-entry registers rather than a RAM: the whole bank must be written in
    // one cycle and must clear on reset.
    genvar gi;
    generate
        for (gi = 0; gi < SC_MAX; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (srst) begin
                    mem_reg[gi] <= '0;
                end else if (cap_en) begin
                    mem_reg[gi] <= cap_data[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (srst) begin
            len_reg <= '0;
        end else if (cap_en) begin
            len_reg <= nsc_len(cap_nsc);
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_idx < IDX_W'(SC_MAX)) begin
            rd_data = mem_reg[rd_idx];
        end
    end

    assign len = len_reg;

endmodule

// File: rtl/ifft_out_serializer.sv
// ---------------------------------------------------------------------------
// ifft_out_serializer
// Captures the 12 parallel complex outputs of the SC-FDMA de-precoding IFFT
// on its done strobe and streams the first N (3/6/12) samples, one per beat,
// over a valid/ready link. Two banks let one symbol drain while the next is
// captured. Samples pass through bit-exact.
// Ports:
//   i_clk      : clock, rising edge
//   i_rst      : synchronous active-high reset
//   i_done     : one-cycle capture strobe from the IFFT
//   i_n_sc     : size code sampled with i_done (0:3, 1:6, 2:12, 3:12)
//   i_x_re     : 12 real IFFT outputs, valid with i_done
//   i_x_im     : 12 imaginary IFFT outputs, valid with i_done
//   o_valid    : a sample is presented
//   i_ready    : consumer accepts; a beat transfers on o_valid & i_ready
//   o_re/o_im  : presented sample
//   o_idx      : index of the presented sample within its symbol
//   o_last     : presented sample is the final one of the symbol
//   o_full     : both banks occupied; a capture now would be lost
//   o_overflow : sticky flag, a capture was dropped since the last reset
// ---------------------------------------------------------------------------
module ifft_out_serializer
    import ifft_ser_pkg::*;
#(
    parameter int DATA_WIDTH = DW,      // must match the package sample width
    parameter int MAX_SC     = SC_MAX
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_done,
    input  logic [1:0]                   i_n_sc,
    input  logic signed [DATA_WIDTH-1:0] i_x_re [0:MAX_SC-1],
    input  logic signed [DATA_WIDTH-1:0] i_x_im [0:MAX_SC-1],
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic signed [DATA_WIDTH-1:0] o_re,
    output logic signed [DATA_WIDTH-1:0] o_im,
    output logic [3:0]                   o_idx,
    output logic                         o_last,
    output logic                         o_full,
    output logic                         o_overflow
);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    logic [1:0]       full_reg;
    logic [1:0]       full_next;
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             overflow_reg;

    // ------------------------------------------------------------------
    // Bank interface
    // ------------------------------------------------------------------
    cplx_t            cap_data [0:MAX_SC-1];
    cplx_t            bank_rd  [0:1];
    logic [IDX_W-1:0] bank_len [0:1];
    logic [1:0]       bank_cap;

    cplx_t            cur_sample;
    logic [IDX_W-1:0] cur_len;
    logic             cur_valid;
    logic             at_last;
    logic             xfer;
    logic             last_xfer;
    logic             wr_free;
    logic             capture;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_SC; gi++) begin : g_pack
            assign cap_data[gi] = cplx_t'{re: i_x_re[gi], im: i_x_im[gi]};
        end

        for (gi = 0; gi < 2; gi++) begin : g_bank
            assign bank_cap[gi] = capture & (wr_ptr_reg == 1'(gi));

            ifft_ser_bank u_bank (
                .clk      (i_clk),
                .srst     (i_rst),
                .cap_en   (bank_cap[gi]),
                .cap_nsc  (nsc_e'(i_n_sc)),
                .cap_data (cap_data),
                .rd_idx   (idx_reg),
                .rd_data  (bank_rd[gi]),
                .len      (bank_len[gi])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake and capture decisions
    // ------------------------------------------------------------------
    assign cur_sample = bank_rd[rd_ptr_reg];
    assign cur_len    = bank_len[rd_ptr_reg];
    assign cur_valid  = full_reg[rd_ptr_reg];
    assign at_last    = (idx_reg == cur_len - 4'd1);
    assign xfer       = cur_valid & i_ready;
    assign last_xfer  = xfer & at_last;

    // The write bank may be the one whose final beat leaves this cycle; its
    // storage is read before the edge, so it can be refilled at that edge.
    assign wr_free = ~full_reg[wr_ptr_reg] | (last_xfer & (rd_ptr_reg == wr_ptr_reg));
    assign capture = i_done & wr_free;

    // Release before set so a same-cycle drain-and-refill leaves the bank full.
    always_comb begin
        full_next = full_reg;
        if (last_xfer) begin
            full_next[rd_ptr_reg] = 1'b0;
        end
        if (capture) begin
            full_next[wr_ptr_reg] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            full_reg     <= '0;
            wr_ptr_reg   <= 1'b0;
            rd_ptr_reg   <= 1'b0;
            idx_reg      <= '0;
            overflow_reg <= 1'b0;
        end else begin
            full_reg <= full_next;
            if (capture) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (last_xfer) begin
                rd_ptr_reg <= ~rd_ptr_reg;
                idx_reg    <= '0;
            end else if (xfer) begin
                idx_reg <= idx_reg + 4'd1;
            end
            if (i_done & ~wr_free) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all derived from registered state, never from i_x_*
    // ------------------------------------------------------------------
    assign o_valid    = cur_valid;
    assign o_re       = cur_sample.re;
    assign o_im       = cur_sample.im;
    assign o_idx      = idx_reg;
    assign o_last     = cur_valid & at_last;
    assign o_full     = &full_reg;
    assign o_overflow = overflow_reg;

endmodule

// File: tb/tb_ifft_out_serializer.sv
// ---------------------------------------------------------------------------
// tb_ifft_out_serializer
// Directed and randomized stimulus for ifft_out_serializer. The reference
// model is a queue of stored symbol lengths plus a flat queue of the samples
// still owed to the consumer; at most two symbols may be held at once.
// ---------------------------------------------------------------------------
module tb_ifft_out_serializer;

    logic               i_clk = 1'b0;
    logic               i_rst;
    logic               i_done;
    logic [1:0]         i_n_sc;
    logic signed [15:0] i_x_re [0:11];
    logic signed [15:0] i_x_im [0:11];
    logic               o_valid;
    logic               i_ready;
    logic signed [15:0] o_re;
    logic signed [15:0] o_im;
    logic [3:0]         o_idx;
    logic               o_last;
    logic               o_full;
    logic               o_overflow;

    ifft_out_serializer dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_done     (i_done),
        .i_n_sc     (i_n_sc),
        .i_x_re     (i_x_re),
        .i_x_im     (i_x_im),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_re       (o_re),
        .o_im       (o_im),
        .o_idx      (o_idx),
        .o_last     (o_last),
        .o_full     (o_full),
        .o_overflow (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model state
    int          len_q  [$];
    logic [31:0] samp_q [$];
    int          pos;
    logic        ovf_m;

    function automatic int len_of(input logic [1:0] nsc);
        return (nsc == 2'd0) ? 3 : (nsc == 2'd1) ? 6 : 12;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        logic        exp_valid;
        logic [31:0] e;
        exp_valid = (len_q.size() > 0);
        chk("valid", {31'd0, o_valid}, {31'd0, exp_valid});
        if (exp_valid) begin
            e = samp_q[0];
            chk("re",   {16'd0, o_re},   {16'd0, e[31:16]});
            chk("im",   {16'd0, o_im},   {16'd0, e[15:0]});
            chk("idx",  {28'd0, o_idx},  32'(pos));
            chk("last", {31'd0, o_last}, {31'd0, (pos == len_q[0] - 1)});
        end else begin
            chk("last_idle", {31'd0, o_last}, 32'd0);
        end
        chk("full",     {31'd0, o_full},     {31'd0, (len_q.size() == 2)});
        chk("overflow", {31'd0, o_overflow}, {31'd0, ovf_m});
    endtask

    // One clock cycle: drive inputs, advance the model at the edge, check.
    task automatic step(input logic done, input logic [1:0] nsc, input logic ready);
        logic xfer;
        logic last;
        int   cap_len;
        i_done  = done;
        i_n_sc  = nsc;
        i_ready = ready;
        @(posedge i_clk);
        xfer = (len_q.size() > 0) && ready;
        last = xfer && (pos == len_q[0] - 1);
        if (xfer) begin
            void'(samp_q.pop_front());
            if (last) begin
                void'(len_q.pop_front());
                pos = 0;
            end else begin
                pos++;
            end
        end
        if (done) begin
            if (len_q.size() < 2) begin
                cap_len = len_of(nsc);
                len_q.push_back(cap_len);
                for (int k = 0; k < cap_len; k++) begin
                    samp_q.push_back({i_x_re[k], i_x_im[k]});
                end
            end else begin
                ovf_m = 1'b1;
            end
        end
        #1;
        i_done = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        i_rst   = 1'b1;
        i_done  = 1'b0;
        i_ready = 1'b0;
        @(posedge i_clk);
        len_q.delete();
        samp_q.delete();
        pos   = 0;
        ovf_m = 1'b0;
        #1;
        i_rst = 1'b0;
        check_all();
        chk("rst_re",  {16'd0, o_re},  32'd0);
        chk("rst_im",  {16'd0, o_im},  32'd0);
        chk("rst_idx", {28'd0, o_idx}, 32'd0);
    endtask

    task automatic fill_ramp();
        for (int k = 0; k < 12; k++) begin
            i_x_re[k] = 16'(k);
            i_x_im[k] = 16'(-k);
        end
    endtask

    task automatic fill_rand();
        for (int k = 0; k < 12; k++) begin
            i_x_re[k] = 16'($urandom);
            i_x_im[k] = 16'($urandom);
        end
    endtask

    initial begin
        i_rst   = 1'b1;
        i_done  = 1'b0;
        i_n_sc  = 2'd0;
        i_ready = 1'b0;
        pos     = 0;
        ovf_m   = 1'b0;
        for (int k = 0; k < 12; k++) begin
            i_x_re[k] = '0;
            i_x_im[k] = '0;
        end
        @(posedge i_clk);
        #1;
        do_reset();

        // 1: 12-point ramp with the consumer always ready
        fill_ramp();
        step(1'b1, 2'd2, 1'b1);
        for (int c = 0; c < 14; c++) step(1'b0, 2'd2, 1'b1);

        // 2: 3-point then 6-point, strobes two cycles apart
        fill_rand();
        step(1'b1, 2'd0, 1'b1);
        step(1'b0, 2'd0, 1'b1);
        fill_rand();
        step(1'b1, 2'd1, 1'b1);
        for (int c = 0; c < 10; c++) step(1'b0, 2'd2, 1'b1);

        // 3: backpressure on a 6-point symbol
        fill_rand();
        step(1'b1, 2'd1, 1'b0);
        for (int c = 0; c < 14; c++) step(1'b0, 2'd1, 1'(c % 2 == 0));

        // 4: three captures while stalled; the third is dropped
        fill_rand();
        step(1'b1, 2'd2, 1'b0);
        step(1'b0, 2'd0, 1'b0);
        fill_rand();
        step(1'b1, 2'd1, 1'b0);
        fill_rand();
        step(1'b1, 2'd0, 1'b0);
        for (int c = 0; c < 3; c++) step(1'b0, 2'd0, 1'b0);
        for (int c = 0; c < 20; c++) step(1'b0, 2'd0, 1'b1);

        // 5: both banks full, capture lands on the final beat
        do_reset();
        fill_rand();
        step(1'b1, 2'd0, 1'b0);
        fill_rand();
        step(1'b1, 2'd1, 1'b0);
        step(1'b0, 2'd0, 1'b1);
        step(1'b0, 2'd0, 1'b1);
        fill_rand();
        step(1'b1, 2'd3, 1'b1);
        for (int c = 0; c < 20; c++) step(1'b0, 2'd0, 1'b1);

        // 6: reset while idx 4 of a 12-point symbol is presented
        fill_rand();
        step(1'b1, 2'd2, 1'b1);
        for (int c = 0; c < 4; c++) step(1'b0, 2'd2, 1'b1);
        chk("pre_rst_idx", {28'd0, o_idx}, 32'd4);
        do_reset();
        fill_rand();
        step(1'b1, 2'd2, 1'b1);
        for (int c = 0; c < 13; c++) step(1'b0, 2'd2, 1'b1);

        // Random traffic
        for (int c = 0; c < 300; c++) begin
            logic d;
            d = ($urandom_range(0, 5) == 0);
            if (d) fill_rand();
            step(d, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0));
        end
        for (int c = 0; c < 30; c++) step(1'b0, 2'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
